// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//   Shares one single-port video memory between NUM_CH requesters. Channel 0
//   is the video fetch port and can optionally be given absolute priority;
//   otherwise every channel is served round-robin. At most one access is
//   issued per cycle. Reads are tracked through a MEM_LAT+1 deep pipeline so
//   the returning data is tagged with the channel that asked for it.
//
// Ports
//   clk        : clock, everything is updated on its rising edge
//   reset_n    : synchronous active-low reset
//   fixed_prio : 1 = channel 0 always wins when eligible, 0 = pure round-robin
//   req        : per-channel request, held by the requester until granted
//   we         : per-channel write enable (qualified by req)
//   addr       : per-channel address, channel n at [n*ADDR_W +: ADDR_W]
//   wdata      : per-channel write data, channel n at [n*DATA_W +: DATA_W]
//   gnt        : one-cycle grant pulse, one-hot or zero
//   rvalid     : one-cycle read-data-valid pulse, one-hot or zero
//   rdata      : read data shared by all channels, held while rvalid is 0
//   mem_addr   : registered memory address
//   mem_we     : registered memory write strobe
//   mem_wdata  : registered memory write data
//   mem_rdata  : memory read data, valid MEM_LAT cycles after mem_addr
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fixed_prio,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int CW = $clog2(NUM_CH);

  // Per-channel views of the packed address / data buses.
  logic [ADDR_W-1:0] addr_ch  [NUM_CH];
  logic [DATA_W-1:0] wdata_ch [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign addr_ch[gi]  = addr[gi*ADDR_W +: ADDR_W];
    assign wdata_ch[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  // Registered state.
  logic [NUM_CH-1:0] gnt_q;
  logic [NUM_CH-1:0] rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [CW-1:0]     ptr_q;          // first channel examined by the search
  logic [CW-1:0]     ptr_d;

  // In-flight tracker: stage k describes the access granted k cycles ago.
  logic              trk_vld_q [MEM_LAT+1];
  logic [CW-1:0]     trk_ch_q  [MEM_LAT+1];
  logic              trk_rd_q  [MEM_LAT+1];

  // Arbitration.
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] cand;
  logic              found;
  logic [CW-1:0]     win;
  logic [CW-1:0]     idx;

  always_comb begin
    // A channel being granted this cycle still shows its req; masking it
    // stops the same request from being served twice.
    eligible = req & ~gnt_q;
    cand     = eligible;
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    ptr_d    = ptr_q;

    if (fixed_prio && eligible[0]) begin
      found = 1'b1;
      win   = '0;
    end else begin
      // Under fixed priority channel 0 never takes part in the rotation.
      if (fixed_prio) begin
        cand[0] = 1'b0;
      end
      for (int off = 0; off < NUM_CH; off++) begin
        if (int'(ptr_q) + off >= NUM_CH) begin
          idx = CW'(int'(ptr_q) + off - NUM_CH);
        end else begin
          idx = CW'(int'(ptr_q) + off);
        end
        if (!found && cand[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end

    // Channel 0 wins under fixed priority leave the rotation untouched.
    if (found && !(fixed_prio && win == '0)) begin
      ptr_d = (win == CW'(NUM_CH - 1)) ? '0 : win + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      ptr_q       <= '0;
      for (int i = 0; i <= MEM_LAT; i++) begin
        trk_vld_q[i] <= 1'b0;
        trk_ch_q[i]  <= '0;
        trk_rd_q[i]  <= 1'b0;
      end
    end else begin
      gnt_q    <= found ? (NUM_CH'(1) << win) : '0;
      mem_we_q <= found && we[win];
      ptr_q    <= ptr_d;
      // Address and data hold their last value when nothing is granted.
      if (found) begin
        mem_addr_q  <= addr_ch[win];
        mem_wdata_q <= wdata_ch[win];
      end

      trk_vld_q[0] <= found;
      trk_ch_q[0]  <= win;
      trk_rd_q[0]  <= found && !we[win];
      for (int i = 1; i <= MEM_LAT; i++) begin
        trk_vld_q[i] <= trk_vld_q[i-1];
        trk_ch_q[i]  <= trk_ch_q[i-1];
        trk_rd_q[i]  <= trk_rd_q[i-1];
      end

      // The last stage lines up with mem_rdata for that access.
      if (trk_vld_q[MEM_LAT] && trk_rd_q[MEM_LAT]) begin
        rvalid_q <= NUM_CH'(1) << trk_ch_q[MEM_LAT];
        rdata_q  <= mem_rdata;
      end else begin
        rvalid_q <= '0;
      end
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3, number of requesting channels, legal range 2..8; channel 0 is the video fetch port.
REQ-002 Parameter ADDR_W, default 16, memory address width in bits.
REQ-003 Parameter DATA_W, default 8, memory data width in bits.
REQ-004 Parameter MEM_LAT, default 1, cycles from mem_addr registered to mem_rdata valid, legal range 1..4.
REQ-005 clk  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous and active-low.
REQ-007 fixed_prio  input  1  1 = channel 0 has absolute priority; 0 = pure round-robin across all channels.
REQ-008 req  input  NUM_CH  per-channel access request, held until granted.
REQ-009 we  input  NUM_CH  per-channel write enable, qualified by req.
REQ-010 addr  input  NUM_CH*ADDR_W  per-channel address, channel n in bits [n*ADDR_W +: ADDR_W].
REQ-011 wdata  input  NUM_CH*DATA_W  per-channel write data, packed like addr.
REQ-012 gnt  output  NUM_CH  one-cycle grant pulse, at most one bit set.
REQ-013 rvalid  output  NUM_CH  one-cycle read-data-valid pulse, at most one bit set.
REQ-014 rdata  output  DATA_W  read data, shared by all channels, qualified by rvalid.
REQ-015 mem_addr  output  ADDR_W  registered memory address.
REQ-016 mem_we  output  1  registered memory write strobe.
REQ-017 mem_wdata  output  DATA_W  registered memory write data.
REQ-018 mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_addr.

Function
REQ-019 The block SHALL issue at most one memory access per clk cycle.
REQ-020 On each edge the block SHALL choose a winner among eligible requests; winner's addr/we/wdata SHALL appear on mem_addr/mem_we/mem_wdata and its gnt bit SHALL be high in the cycle following that edge.
REQ-021 A channel whose gnt is high in the current cycle SHALL be ineligible in that cycle, so a held req is never granted twice; back-to-back grants to one channel are impossible.
REQ-022 Round-robin: the search SHALL start at the channel after the last granted one, wrapping NUM_CH-1 to 0; the pointer SHALL update only on a grant.
REQ-023 fixed_prio=1: an eligible channel 0 SHALL win unconditionally; otherwise the round-robin rule SHALL apply to channels 1..NUM_CH-1 and the pointer SHALL not be advanced by channel 0 grants.
REQ-024 No eligible request: gnt SHALL be 0, mem_we SHALL be 0, mem_addr and mem_wdata SHALL hold their previous values.
REQ-025 mem_we SHALL be high for exactly the one cycle of a granted write.
REQ-026 A granted read SHALL produce rvalid for that channel exactly MEM_LAT+1 cycles after its gnt cycle, with rdata equal to mem_rdata registered; writes SHALL produce no rvalid.
REQ-027 The in-flight tracker SHALL be a MEM_LAT+1 deep shift of (valid, channel id, read flag), so reads returned back-to-back from different channels keep order and identity.
REQ-028 rdata SHALL hold its last value when rvalid is 0.
REQ-029 A req deasserted before its grant SHALL be treated as withdrawn, with no access issued.

Reset
REQ-030 While reset_n is low at an edge: gnt, rvalid, mem_we SHALL be 0; mem_addr, mem_wdata, rdata SHALL be 0; round-robin pointer SHALL be 0; tracker SHALL be cleared.
REQ-031 Reset mid-operation SHALL discard in-flight reads: no rvalid for any access granted before reset.
REQ-032 The first edge with reset_n high SHALL arbitrate normally, starting the search at channel 0.

Verification
REQ-033 NUM_CH=3, MEM_LAT=1, fixed_prio=0; req=3'b111 held continuously -> gnt sequence 001,010,100,001 on consecutive cycles.
REQ-034 Channel 1 read, addr=16'h0123, memory model returns 8'h5A -> gnt[1] at cycle T, mem_addr=16'h0123 at T, rvalid=3'b010 and rdata=8'h5A at T+2.
REQ-035 fixed_prio=1, req=3'b111 held, each channel drops req after its grant and re-raises 1 cycle later -> channel 0 granted every eligible cycle, channels 1 and 2 alternate in the remaining cycles.
REQ-036 Channel 2 write addr=16'h00FF wdata=8'hC3 -> mem_we high for exactly one cycle with mem_addr=16'h00FF, mem_wdata=8'hC3, gnt=3'b100; no rvalid follows.
REQ-037 MEM_LAT=3, reads granted to ch0 then ch1 on cycles T and T+1 -> rvalid=001 at T+4, 010 at T+5, data matching respective addresses.
REQ-038 Read granted at T, reset_n low at T+1 for one cycle -> no rvalid at T+2 or later, all outputs 0 during reset, next grant starts search from channel 0.
